// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer.
// Accepts 16-bit mono samples qualified by a one-cycle change strobe and
// shifts each one out twice per frame (left slot, then right slot), MSB first.
// BCLK and LRCLK are derived from clk; all link outputs are registered.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   WAIT_FIRST | link clocks run, zero frames sent, underrun not reported
//   STREAM     | first sample seen; missing samples repeat the last one and
//              | report underrun
module i2s_tx_serializer #(
  parameter int PKT_WIDTH = 16,
  parameter int BCLK_DIV  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PKT_WIDTH-1:0] pkt_reg_i,
  input  logic                 pktChanged_reg_i,
  output logic                 bclk_o,
  output logic                 lrclk_o,
  output logic                 sdata_o,
  output logic                 frameStart_o,
  output logic                 underrun_o,
  output logic                 overrun_o
);

  localparam int FRAME = 2 * PKT_WIDTH;
  localparam int CNT_W = $clog2(FRAME);
  localparam int DIV_W = $clog2(BCLK_DIV + 1);

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    STREAM     = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [DIV_W-1:0]     r_div_cnt;
  logic                 r_bclk;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic                 r_lrclk;
  logic                 r_sdata;
  logic [FRAME-1:0]     r_shift;
  logic [PKT_WIDTH-1:0] r_pending;
  logic                 r_pending_valid;
  logic [PKT_WIDTH-1:0] r_last;
  logic                 r_frame_start;
  logic                 r_underrun;
  logic                 r_overrun;

  logic                 w_div_tc;
  logic                 w_fall;
  logic                 w_bit_last;
  logic                 w_boundary;
  logic [CNT_W-1:0]     w_bit_nxt;
  logic                 w_lr_nxt;
  logic [PKT_WIDTH-1:0] w_sample;
  logic                 w_underrun_nxt;
  logic                 w_overrun_nxt;

  // Shared decode: falling BCLK event, frame boundary and next-bit values
  always_comb begin
    w_div_tc   = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
    w_fall     = w_div_tc & r_bclk;
    w_bit_last = (r_bit_cnt == CNT_W'(FRAME - 1));
    w_boundary = w_fall & w_bit_last;
    w_bit_nxt  = w_bit_last ? '0 : r_bit_cnt + CNT_W'(1);
    // LRCLK switches one BCLK ahead of each slot's MSB
    w_lr_nxt   = (w_bit_nxt >= CNT_W'(PKT_WIDTH - 1)) &&
                 (w_bit_nxt <= CNT_W'(FRAME - 2));
    w_sample   = r_pending_valid ? r_pending : r_last;
    // A boundary in the same cycle consumes the old pending, so no overrun
    w_overrun_nxt = pktChanged_reg_i & r_pending_valid & ~w_boundary;
  end

  // BCLK divider: toggle at terminal count, wrap the counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_div_tc) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Bit counter, word select and serial data advance on BCLK falling edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= CNT_W'(FRAME - 1);
      r_lrclk   <= 1'b0;
      r_sdata   <= 1'b0;
      r_shift   <= '0;
      r_last    <= '0;
    end else if (w_fall) begin
      r_bit_cnt <= w_bit_nxt;
      r_lrclk   <= w_lr_nxt;
      if (w_bit_last) begin
        // MSB goes out now, the remaining 2*PKT_WIDTH-1 bits wait in shift
        r_sdata <= w_sample[PKT_WIDTH-1];
        r_shift <= {w_sample[PKT_WIDTH-2:0], w_sample, 1'b0};
        r_last  <= w_sample;
      end else begin
        r_sdata <= r_shift[FRAME-1];
        r_shift <= {r_shift[FRAME-2:0], 1'b0};
      end
    end
  end

  // Sample capture; newest strobe always wins the pending slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
    end else if (pktChanged_reg_i) begin
      r_pending       <= pkt_reg_i;
      r_pending_valid <= 1'b1;
    end else if (w_boundary) begin
      r_pending_valid <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_FIRST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and underrun decision
  always_comb begin
    w_state_nxt    = r_state;
    w_underrun_nxt = 1'b0;
    case (r_state)
      WAIT_FIRST: begin
        if (w_boundary && r_pending_valid) begin
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (w_boundary && !r_pending_valid) begin
          w_underrun_nxt = 1'b1;
        end
      end
      default: w_state_nxt = WAIT_FIRST;
    endcase
  end

  // Registered status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_frame_start <= w_boundary;
      r_underrun    <= w_underrun_nxt;
      r_overrun     <= w_overrun_nxt;
    end
  end

  assign bclk_o       = r_bclk;
  assign lrclk_o      = r_lrclk;
  assign sdata_o      = r_sdata;
  assign frameStart_o = r_frame_start;
  assign underrun_o   = r_underrun;
  assign overrun_o    = r_overrun;

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
Sink-side counterpart of the delay buffer's strobed packet interface. It accepts 16-bit samples qualified by a one-cycle change strobe, in the same form the delay buffer emits on pktDelayed_reg_o / pktDelayedChanged_reg_o. It serializes them onto an I2S transmit link to the codec, generating BCLK and LRCLK from the system clock. The mono sample is sent on both channels, and every frame start is reported upstream.

Parameters:
PKT_WIDTH, 16, sample width; one channel slot = PKT_WIDTH BCLK periods, frame = 2*PKT_WIDTH
BCLK_DIV, 4, clk cycles per BCLK half-period (must be >= 1); BCLK period = 2*BCLK_DIV clk

Ports:
clk  input  1  system clock, single clock domain
rst_n  input  1  asynchronous active-low reset
pkt_reg_i  input  PKT_WIDTH  sample to transmit, two's complement
pktChanged_reg_i  input  1  one-cycle strobe, pkt_reg_i valid
bclk_o  output  1  I2S bit clock, registered
lrclk_o  output  1  I2S word select, 0 = left, registered
sdata_o  output  1  I2S serial data, MSB first, registered
frameStart_o  output  1  one-clk pulse when a new frame is loaded
underrun_o  output  1  one-clk pulse, frame loaded with no new sample (STREAM only)
overrun_o  output  1  one-clk pulse, strobe arrived while pending sample still unconsumed

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; div_cnt=0; bitCnt=2*PKT_WIDTH-1; pending=0, pendingValid=0; shift=0; lastSample=0.
  - State = WAIT_FIRST.
- BCLK generation:
  - div_cnt counts 0..BCLK_DIV-1 every clk.
  - At terminal count bclk_o toggles and div_cnt wraps.
  - First rise at BCLK_DIV clk edges after reset release; first fall at 2*BCLK_DIV.
- Falling-edge event: the clk edge on which bclk_o goes 1->0. bitCnt, lrclk_o and sdata_o update only on this edge.
  - bitCnt increments mod 2*PKT_WIDTH.
  - lrclk_o = 1 for bitCnt in [PKT_WIDTH-1, 2*PKT_WIDTH-2], else 0. LRCLK leads MSB by one BCLK (standard I2S).
  - sdata_o = shift MSB.
- Frame boundary (bitCnt wraps 2*PKT_WIDTH-1 -> 0):
  - shift loads {S,S}, where S = pending if pendingValid else lastSample.
  - sdata_o takes S MSB on the same edge.
  - pendingValid cleared; lastSample = S; frameStart_o pulses.
- Capture: on pktChanged_reg_i=1, pending = pkt_reg_i and pendingValid = 1.
  - If pendingValid was already 1 and no boundary occurs this cycle, overrun_o pulses (newest sample wins).
- Simultaneous strobe and frame boundary:
  - The frame loads the old pending/lastSample.
  - The new sample goes to pending with pendingValid=1.
  - No overrun.
- FSM:
  - WAIT_FIRST: link clocks run, frames transmit zeros, underrun_o suppressed. Moves to STREAM at the first boundary where pendingValid=1; that frame carries the sample.
  - STREAM: at a boundary with pendingValid=0, repeat lastSample and pulse underrun_o. There is no return to WAIT_FIRST except by reset.
- Latency: a strobe at least one clk before a boundary has its MSB on sdata_o at that boundary's falling edge. Otherwise it is sent one frame later.
- Reset mid-frame: all outputs drop to 0 immediately; the in-flight sample is discarded.
- pkt_reg_i is ignored when the strobe is low. Strobes held high are captured every cycle, and each cycle after the first pulses overrun_o.

Test Plan:
1. Reset/idle, BCLK_DIV=2: hold rst_n=0 for 5 clk, then release -> all outputs 0 during reset; bclk_o period 4 clk; lrclk_o period 128 clk; sdata_o=0; frameStart_o every 128 clk; underrun_o never pulses.
2. Single sample: strobe 16'hAAAA 10 clk before a boundary -> left slot bits 1010..., right slot identical; lrclk_o low one BCLK before the left MSB; state STREAM after that boundary.
3. Underrun: after test 2 send nothing -> next frame repeats 16'hAAAA and underrun_o pulses once at that boundary.
4. Overrun: strobe 16'h1234, then 16'h5678 three clk later, same frame -> overrun_o pulses once; next frame carries 16'h5678.
5. Simultaneous: strobe 16'hBEEF on the boundary clk while pending=16'hCCCC -> that frame sends 16'hCCCC, next frame sends 16'hBEEF, no overrun.
6. Mid-frame reset: assert rst_n=0 at bitCnt=7 -> outputs 0 in the same timestep (asynchronous); after release, zero frames until a new strobe, underrun_o quiet.
